// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_types_pkg
// Brief    : Shared types and constants for the multi-cycle RV32 core.
// Revision : 1.0 - adds write-back unit state encoding and REG_ZERO
// ============================================================================
package cpu_types_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // LSU -> WBU payload; 'valid' distinguishes a real instruction from a bubble
    typedef struct packed {
        logic        valid;
        logic        reg_wen;
        logic [4:0]  rd_addr;
        logic [31:0] wb_data;
        logic [31:0] pc_target;
    } lsu_wb_t;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COMMIT   = 2'd1,
        S_REDIRECT = 2'd2
    } wbu_state_e;

endpackage
`default_nettype wire

// File: rtl/stage_if.sv
`default_nettype none
// ============================================================================
// Module   : stage_if
// Brief    : Valid/ready handshake between pipeline stages carrying lsu_wb_t.
// Revision : 1.0 - initial version
// ============================================================================
interface stage_if;
    import cpu_types_pkg::*;

    logic    valid;
    logic    ready;
    lsu_wb_t data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);

endinterface
`default_nettype wire

// File: rtl/regfile.sv
`default_nettype none
// ============================================================================
// Module   : regfile
// Brief    : Architectural register file, 2 combinational reads, 1 sync write.
// Revision : 1.0 - initial version
// ============================================================================
module regfile #(
    parameter int NUM_REGS = 32,
    parameter int XLEN     = 32,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [XLEN-1:0]   i_wr_data,
    input  logic [ADDR_W-1:0] i_rd1_addr,
    output logic [XLEN-1:0]   o_rd1_data,
    input  logic [ADDR_W-1:0] i_rd2_addr,
    output logic [XLEN-1:0]   o_rd2_data
);

    logic [XLEN-1:0] r_regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_wr_en && (i_wr_addr != '0)) begin
            r_regs[i_wr_addr] <= i_wr_data;
        end
    end

    // x0 is forced to zero on the read side as well as never written
    assign o_rd1_data = (i_rd1_addr == '0) ? '0 : r_regs[i_rd1_addr];
    assign o_rd2_data = (i_rd2_addr == '0) ? '0 : r_regs[i_rd2_addr];

endmodule
`default_nettype wire

// File: rtl/wbu.sv
`default_nettype none
// ============================================================================
// Module   : wbu
// Brief    : Write-back unit: commits LSU results to the register file and
//            hands the next PC to the IFU. Optional retire counter and commit
//            trace enabled by WBU_RETIRE_COUNTER_EN.
// Revision : 1.0 - initial version
// ============================================================================
module wbu
    import cpu_types_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    stage_if.slave          wbu_in,
    input  logic [4:0]      rs1_addr,
    output logic [XLEN-1:0] rs1_data,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs2_data,
    output logic            pc_valid,
    input  logic            pc_ready,
    output logic [31:0]     pc_next,
    output logic [63:0]     retire_cnt
);

    localparam int c_ADDR_W = $clog2(NUM_REGS);

    wbu_state_e r_state;
    lsu_wb_t    r_wb;
    logic       r_ready;
    logic       r_pc_valid;
    logic [31:0] r_pc_next;

    logic w_fire;
    logic w_commit;
    logic w_wr_en;

    assign w_fire   = wbu_in.valid && r_ready;
    assign w_commit = (r_state == S_COMMIT) && r_wb.valid;
    assign w_wr_en  = w_commit && r_wb.reg_wen && (r_wb.rd_addr != REG_ZERO);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wb       <= '0;
            r_ready    <= 1'b1;
            r_pc_valid <= 1'b0;
            r_pc_next  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_fire) begin
                        r_wb    <= wbu_in.data;
                        r_ready <= 1'b0;
                        r_state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    // A bubble retires nothing and skips the redirect entirely
                    if (r_wb.valid) begin
                        r_pc_valid <= 1'b1;
                        r_pc_next  <= r_wb.pc_target;
                        r_state    <= S_REDIRECT;
                    end else begin
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                S_REDIRECT: begin
                    if (r_pc_valid && pc_ready) begin
                        r_pc_valid <= 1'b0;
                        r_ready    <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_pc_valid <= 1'b0;
                    r_ready    <= 1'b1;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign wbu_in.ready = r_ready;
    assign pc_valid     = r_pc_valid;
    assign pc_next      = r_pc_next;

    regfile #(
        .NUM_REGS (NUM_REGS),
        .XLEN     (XLEN),
        .ADDR_W   (c_ADDR_W)
    ) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .i_wr_en    (w_wr_en),
        .i_wr_addr  (r_wb.rd_addr[c_ADDR_W-1:0]),
        .i_wr_data  (XLEN'(r_wb.wb_data)),
        .i_rd1_addr (rs1_addr[c_ADDR_W-1:0]),
        .o_rd1_data (rs1_data),
        .i_rd2_addr (rs2_addr[c_ADDR_W-1:0]),
        .o_rd2_data (rs2_data)
    );

`ifdef WBU_RETIRE_COUNTER_EN
    logic [63:0] r_retire_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_retire_cnt <= '0;
        end else if (w_commit) begin
            r_retire_cnt <= r_retire_cnt + 64'd1;
        end
    end

    assign retire_cnt = r_retire_cnt;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && w_commit) begin
            $display("wbu retire: rd=x%0d wb_data=0x%08h pc_target=0x%08h",
                     r_wb.rd_addr, r_wb.wb_data, r_wb.pc_target);
        end
    end
`endif
`else
    assign retire_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wbu.sv
`default_nettype none
// ============================================================================
// Module   : tb_wbu
// Brief    : Self-checking bench for wbu: directed scenarios plus random traffic
//            against a transaction-level model.
// Revision : 1.0 - initial version
// ============================================================================
module tb_wbu;
    import cpu_types_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        pc_valid, pc_ready;
    logic [31:0] pc_next;
    logic [63:0] retire_cnt;

    stage_if u_if ();

    wbu #(.NUM_REGS(32), .XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .wbu_in     (u_if.slave),
        .rs1_addr   (rs1_addr),
        .rs1_data   (rs1_data),
        .rs2_addr   (rs2_addr),
        .rs2_data   (rs2_data),
        .pc_valid   (pc_valid),
        .pc_ready   (pc_ready),
        .pc_next    (pc_next),
        .retire_cnt (retire_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: at most one instruction in flight; its age counts cycles since accept
    logic [31:0] m_regs [32];
    logic        m_inflight;
    int          m_age;
    lsu_wb_t     m_pl;
    logic [63:0] m_retire;
    logic        m_pc_zero;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_inflight = 1'b0;
        m_age      = 0;
        m_pl       = '0;
        m_retire   = '0;
        m_pc_zero  = 1'b1;
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : m_regs[a];
    endfunction

    // One clock cycle: compare registered outputs, drive inputs, compare reads,
    // then advance the model across the coming edge.
    task automatic step(input logic iv, input lsu_wb_t pl, input logic prdy,
                        input logic r, input logic [4:0] a1, input logic [4:0] a2);
        logic m_pv;
        @(negedge clk);
        m_pv = m_inflight && (m_age == 2);
        chk("in_ready", {63'd0, u_if.ready}, {63'd0, !m_inflight});
        chk("pc_valid", {63'd0, pc_valid}, {63'd0, m_pv});
        if (m_pv)           chk("pc_next", {32'd0, pc_next}, {32'd0, m_pl.pc_target});
        else if (m_pc_zero) chk("pc_next_rst", {32'd0, pc_next}, 64'd0);
`ifdef WBU_RETIRE_COUNTER_EN
        chk("retire_cnt", retire_cnt, m_retire);
`else
        chk("retire_cnt", retire_cnt, 64'd0);
`endif
        u_if.valid = iv;
        u_if.data  = pl;
        pc_ready   = prdy;
        rst        = r;
        rs1_addr   = a1;
        rs2_addr   = a2;
        #1;
        chk("rs1_data", {32'd0, rs1_data}, {32'd0, m_read(a1)});
        chk("rs2_data", {32'd0, rs2_data}, {32'd0, m_read(a2)});
        if (r) begin
            model_reset();
        end else if (!m_inflight) begin
            if (iv) begin
                m_inflight = 1'b1;
                m_age      = 1;
                m_pl       = pl;
            end
        end else if (m_age == 1) begin
            if (m_pl.valid) begin
                m_retire = m_retire + 64'd1;
                if (m_pl.reg_wen && m_pl.rd_addr != 5'd0) m_regs[m_pl.rd_addr] = m_pl.wb_data;
                m_age = 2;
            end else begin
                m_inflight = 1'b0;
            end
        end else if (prdy) begin
            m_inflight = 1'b0;
        end
        if (m_inflight && m_age == 2) m_pc_zero = 1'b0;
    endtask

    function automatic lsu_wb_t mk(input logic v, input logic w, input logic [4:0] rd,
                                   input logic [31:0] d, input logic [31:0] t);
        lsu_wb_t p;
        p.valid = v; p.reg_wen = w; p.rd_addr = rd; p.wb_data = d; p.pc_target = t;
        return p;
    endfunction

    task automatic idle(input logic prdy, input logic [4:0] a1);
        step(1'b0, '0, prdy, 1'b0, a1, 5'd0);
    endtask

    initial begin
        lsu_wb_t p;
        model_reset();
        rst = 1'b1; u_if.valid = 1'b0; u_if.data = '0;
        pc_ready = 1'b0; rs1_addr = '0; rs2_addr = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // reset state
        idle(1'b0, 5'd5);
        chk("rst_ready", {63'd0, u_if.ready}, 64'd1);
        chk("rst_x5", {32'd0, rs1_data}, 64'd0);

        // basic commit
        step(1'b1, mk(1, 1, 5'd5, 32'hDEADBEEF, 32'h80000004), 1'b1, 1'b0, 5'd5, 5'd0);
        idle(1'b1, 5'd5);
        chk("basic_n1_pcv", {63'd0, pc_valid}, 64'd0);
        chk("basic_n1_rdy", {63'd0, u_if.ready}, 64'd0);
        idle(1'b1, 5'd5);
        chk("basic_n2_pcv", {63'd0, pc_valid}, 64'd1);
        chk("basic_n2_pc", {32'd0, pc_next}, 64'h80000004);
        chk("basic_n2_x5", {32'd0, rs1_data}, 64'hDEADBEEF);
        idle(1'b1, 5'd5);
        chk("basic_n3_rdy", {63'd0, u_if.ready}, 64'd1);

        // x0 write is dropped, redirect still happens
        step(1'b1, mk(1, 1, 5'd0, 32'h12345678, 32'h00000040), 1'b1, 1'b0, 5'd0, 5'd0);
        idle(1'b1, 5'd0);
        idle(1'b1, 5'd0);
        chk("x0_read", {32'd0, rs1_data}, 64'd0);
        chk("x0_pcv", {63'd0, pc_valid}, 64'd1);
        chk("x0_pc", {32'd0, pc_next}, 64'h40);

        // IFU stall for 4 cycles
        step(1'b1, mk(1, 1, 5'd9, 32'h0000_0099, 32'h00000100), 1'b0, 1'b0, 5'd9, 5'd5);
        idle(1'b0, 5'd9);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, mk(1, 1, 5'd3, 32'h1, 32'h2), 1'b0, 1'b0, 5'd9, 5'd5);
            chk("stall_pcv", {63'd0, pc_valid}, 64'd1);
            chk("stall_pc", {32'd0, pc_next}, 64'h100);
            chk("stall_rdy", {63'd0, u_if.ready}, 64'd0);
        end
        idle(1'b1, 5'd9);
        idle(1'b0, 5'd9);
        chk("stall_rel_rdy", {63'd0, u_if.ready}, 64'd1);
        chk("stall_rel_pcv", {63'd0, pc_valid}, 64'd0);

        // bubble, then store
        step(1'b1, mk(0, 1, 5'd9, 32'hBAD0BAD0, 32'h200), 1'b1, 1'b0, 5'd9, 5'd0);
        idle(1'b1, 5'd9);
        idle(1'b1, 5'd9);
        chk("bubble_rdy", {63'd0, u_if.ready}, 64'd1);
        chk("bubble_pcv", {63'd0, pc_valid}, 64'd0);
        chk("bubble_x9", {32'd0, rs1_data}, 64'h99);
        step(1'b1, mk(1, 0, 5'd9, 32'hBAD0BAD0, 32'h300), 1'b1, 1'b0, 5'd9, 5'd0);
        idle(1'b1, 5'd9);
        idle(1'b1, 5'd9);
        chk("store_pcv", {63'd0, pc_valid}, 64'd1);
        chk("store_pc", {32'd0, pc_next}, 64'h300);
        chk("store_x9", {32'd0, rs1_data}, 64'h99);
        idle(1'b1, 5'd9);

        // reset during commit
        step(1'b1, mk(1, 1, 5'd7, 32'h55, 32'h400), 1'b1, 1'b0, 5'd7, 5'd0);
        step(1'b0, '0, 1'b1, 1'b1, 5'd7, 5'd0);
        idle(1'b1, 5'd7);
        chk("rstc_x7", {32'd0, rs1_data}, 64'd0);
        chk("rstc_pcv", {63'd0, pc_valid}, 64'd0);
        chk("rstc_rdy", {63'd0, u_if.ready}, 64'd1);

        // retire counter: 10 valid + 2 bubbles
        step(1'b0, '0, 1'b0, 1'b1, 5'd0, 5'd0);
        for (int i = 0; i < 12; i++) begin
            logic v;
            v = !(i == 3 || i == 8);
            step(1'b1, mk(v, 1, 5'(i + 1), 32'(i * 3), 32'(i * 4)), 1'b1, 1'b0, 5'd0, 5'd0);
            idle(1'b1, 5'd0);
            if (v) idle(1'b1, 5'd0);
        end
        idle(1'b1, 5'd0);
`ifdef WBU_RETIRE_COUNTER_EN
        chk("retire_10", retire_cnt, 64'd10);
`else
        chk("retire_off", retire_cnt, 64'd0);
`endif

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            p = mk($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7,
                   5'($urandom_range(0, 31)), $urandom, $urandom);
            step($urandom_range(0, 1) == 1, p, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 99) == 0,
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end
        idle(1'b0, 5'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
